// File: rtl/seq_alu_muldiv.sv
// Sequential ALU: single-cycle logic/shift/compare ops plus WIDTH-cycle iterative
// multiply (shift-add) and divide (restoring) that update the HI/LO registers.
module seq_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   ShiftAmount,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] HiResult,
    output logic [WIDTH-1:0] LoResult,
    output logic             DivByZero
);

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_MULT = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011, OP_OR   = 5'b00100, OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_NOR  = 5'b00110, OP_SLL  = 5'b00111, OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01010, OP_MULTU = 5'b01101, OP_SLT = 5'b01110;
    localparam logic [4:0] OP_SLTU = 5'b10000, OP_SLLV = 5'b10001, OP_SRLV = 5'b10010;
    localparam logic [4:0] OP_SRAV = 5'b10011, OP_MOVE = 5'b10101, OP_LUI  = 5'b10110;
    localparam logic [4:0] OP_DIV  = 5'b11011, OP_DIVU = 5'b11100, OP_MADD = 5'b11101;
    localparam logic [4:0] OP_MSUB = 5'b11110;

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    function automatic logic is_multi(input logic [4:0] c);
        return (c == OP_MULT) || (c == OP_MULTU) || (c == OP_DIV) || (c == OP_DIVU) ||
               (c == OP_MADD) || (c == OP_MSUB);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] c);
        return (c == OP_MULT) || (c == OP_DIV) || (c == OP_MADD) || (c == OP_MSUB);
    endfunction

    logic [CW-1:0]    cnt;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] acc, lo_q, mcand, a_q;
    logic             neg_q, neg_r;
    logic             accept, last, sgn, is_div;
    logic [WIDTH-1:0] alu_res, a_mag, b_mag;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] diff, step_acc, step_lo;
    logic             ge;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic             fin_dbz;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = Start && (state == IDLE);
        last       = (state == RUN) && (cnt == CNT_LAST);
        Busy       = (state == RUN);
        case (state)
            IDLE: if (accept && is_multi(ALUControl)) state_next = RUN;
            RUN:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SLL:  alu_res = B << ShiftAmount;
            OP_SRL:  alu_res = B >> ShiftAmount;
            OP_SRA:  alu_res = $unsigned($signed(B) >>> ShiftAmount);
            OP_SLLV: alu_res = B << A[SHW-1:0];
            OP_SRLV: alu_res = B >> A[SHW-1:0];
            OP_SRAV: alu_res = $unsigned($signed(B) >>> A[SHW-1:0]);
            OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: alu_res = WIDTH'(A < B);
            OP_LUI:  alu_res = B << (WIDTH / 2);
            OP_MOVE: alu_res = A;
            default: alu_res = WIDTH'(1);
        endcase
    end

    // Operands are held as magnitudes; the sign is reapplied once the iteration ends.
    always_comb begin
        sgn   = is_signed_op(ALUControl);
        a_mag = (sgn && A[WIDTH-1]) ? -A : A;
        b_mag = (sgn && B[WIDTH-1]) ? -B : B;
    end

    always_comb begin
        is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
        sum     = {1'b0, acc} + {1'b0, (lo_q[0] ? mcand : '0)};
        shifted = {acc, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, mcand};
        diff    = shifted[WIDTH-1:0] - mcand;
        if (is_div) begin
            step_acc = ge ? diff : shifted[WIDTH-1:0];
            step_lo  = {lo_q[WIDTH-2:0], ge};
        end else begin
            step_acc = sum[WIDTH:1];
            step_lo  = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod    = {step_acc, step_lo};
        prod_s  = neg_q ? -prod : prod;
        fin_dbz = 1'b0;
        case (op_q)
            OP_MADD: {fin_hi, fin_lo} = {HiResult, LoResult} + prod_s;
            OP_MSUB: {fin_hi, fin_lo} = {HiResult, LoResult} - prod_s;
            OP_DIV, OP_DIVU: begin
                if (mcand == '0) begin
                    fin_lo  = '1;
                    fin_hi  = a_q;
                    fin_dbz = 1'b1;
                end else begin
                    fin_lo = neg_q ? -step_lo : step_lo;
                    fin_hi = neg_r ? -step_acc : step_acc;
                end
            end
            default: {fin_hi, fin_lo} = prod_s;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            HiResult  <= '0;
            LoResult  <= '0;
            DivByZero <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
            acc       <= '0;
            lo_q      <= '0;
            mcand     <= '0;
            a_q       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                if (is_multi(ALUControl)) begin
                    op_q  <= ALUControl;
                    acc   <= '0;
                    lo_q  <= a_mag;
                    mcand <= b_mag;
                    a_q   <= A;
                    neg_q <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r <= sgn && A[WIDTH-1];
                    cnt   <= '0;
                end else begin
                    Done      <= 1'b1;
                    ALUResult <= alu_res;
                    Zero      <= (alu_res == '0);
                    DivByZero <= 1'b0;
                    if (ALUControl == OP_MOVE) begin
                        HiResult <= A;
                        LoResult <= A;
                    end
                end
            end else if (state == RUN) begin
                acc  <= step_acc;
                lo_q <= step_lo;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    Done      <= 1'b1;
                    ALUResult <= fin_lo;
                    Zero      <= (fin_lo == '0);
                    HiResult  <= fin_hi;
                    LoResult  <= fin_lo;
                    DivByZero <= fin_dbz;
                end
            end
        end
    end

endmodule

// File: doc/seq_alu_muldiv.md
SEQ_ALU_MULDIV -- requirements
Module: seq_alu_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 Start  input  1  operation request, sampled only when Busy=0.
REQ-007 ALUControl  input  5  operation select, captured with Start.
REQ-008 A, B  input  WIDTH each  operands, captured with Start.
REQ-009 ShiftAmount  input  SHW  constant shift amount, captured with Start.
REQ-010 Busy  output  1  multi-cycle operation in progress.
REQ-011 Done  output  1  one-cycle pulse: ALUResult/Zero (and HI/LO, if updated) valid.
REQ-012 ALUResult  output  WIDTH  registered result.
REQ-013 Zero  output  1  registered (ALUResult==0).
REQ-014 HiResult, LoResult  output  WIDTH each  architectural HI/LO registers.
REQ-015 DivByZero  output  1  sticky per-op flag, valid with Done.

Function
REQ-016 Single-cycle codes: 00000 add, 00001 sub (both signed, wrap, no trap), 00011 and, 00100 or, 00101 xor, 00110 nor, 00111 sll B by ShiftAmount, 01000 srl, 01010 sra, 10001/10010/10011 sll/srl/sra B by A[SHW-1:0], 01110 slt signed, 10000 sltu, 10110 B<<(WIDTH/2), 10101 move (ALUResult=A, HI=A, LO=A).
REQ-017 Multi-cycle codes: 00010 mult, 01101 multu, 11011 div, 11100 divu, 11101 madd ({HI,LO}+=signed A*B), 11110 msub ({HI,LO}-=signed A*B).
REQ-018 Any other code SHALL complete in one cycle with ALUResult=1, HI/LO unchanged.
REQ-019 State machine SHALL have states IDLE and RUN; IDLE->RUN on accepted multi-cycle Start; RUN->IDLE when iteration counter reaches WIDTH.
REQ-020 Single-cycle op accepted at edge k SHALL give Done=1, updated ALUResult/Zero after edge k, Busy staying 0.
REQ-021 Multi-cycle op accepted at edge k SHALL give Busy=1 after edges k..k+WIDTH-1, then Busy=0, Done=1 and results after edge k+WIDTH (latency exactly WIDTH cycles, data-independent).
REQ-022 Multiply SHALL be iterative shift-add (one bit per cycle); signed variants produce the exact 2*WIDTH-bit two's-complement product; HI=upper, LO=lower, ALUResult=lower.
REQ-023 Divide SHALL be iterative restoring (one quotient bit per cycle); LO=quotient, HI=remainder, ALUResult=quotient; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-024 Divide by zero SHALL still take WIDTH cycles: LO=all ones, HI=A, DivByZero=1; otherwise DivByZero=0.
REQ-025 Signed div of most-negative by -1 SHALL give LO=most-negative, HI=0, DivByZero=0.
REQ-026 HI/LO SHALL change only on Done of codes in REQ-016 move or REQ-017; madd/msub read HI/LO at acceptance.
REQ-027 Start while Busy=1 SHALL be ignored (no capture, no effect on running op).
REQ-028 Start in the same cycle Done pulses SHALL be accepted (back-to-back, Busy=0 then).
REQ-029 Done SHALL be high for exactly one cycle per accepted op; ALUResult/Zero hold until the next Done.

Reset
REQ-030 Reset=1 at a rising edge SHALL force IDLE, Busy=0, Done=0, ALUResult=0, Zero=1, HiResult=0, LoResult=0, DivByZero=0, iteration counter=0.
REQ-031 Reset SHALL abort any op in progress; the aborted op SHALL never produce Done; Reset has priority over Start.

Verification (WIDTH=32)
REQ-032 add A=7, B=0xFFFFFFFD, Start 1 cycle -> next cycle Done=1, ALUResult=4, Zero=0, Busy never 1.
REQ-033 mult A=0xFFFFFFFD, B=5 -> Busy 32 cycles, Done on 32nd, HiResult=0xFFFFFFFF, LoResult=0xFFFFFFF1.
REQ-034 div A=0xFFFFFFF9 (-7), B=2 -> LoResult=0xFFFFFFFD, HiResult=0xFFFFFFFF, DivByZero=0; divu A=9, B=0 -> LoResult=0xFFFFFFFF, HiResult=9, DivByZero=1, latency 32.
REQ-035 multu 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE; then madd A=1, B=1 back-to-back on Done -> HI=1, LO=0xFFFFFFFF; Start pulses during Busy -> no effect.
REQ-036 Reset asserted on 10th cycle of div -> next cycle Busy=0, Done=0, HI=LO=0, Zero=1; no Done for 40 following cycles without Start.
